// File: rtl/imm_gen_pkg.sv
// Shared constants for the immediate generator: format select codes and the
// OP-IMM shift encodings that switch the I-format into shamt mode.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_U = 3'd2,
        IMM_B = 3'd3,
        IMM_J = 3'd4,
        IMM_Z = 3'd5
    } imm_sel_e;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [2:0] F3_SLLI  = 3'b001;
    localparam logic [2:0] F3_SRXI  = 3'b101;

    // SLLI/SRLI/SRAI carry a shift amount rather than a signed immediate
    function automatic logic is_shift_imm(input logic [31:0] instr);
        return (instr[6:0] == OP_IMM) &&
               ((instr[14:12] == F3_SLLI) || (instr[14:12] == F3_SRXI));
    endfunction

endpackage

// File: rtl/imm_gen_if.sv
// Handshake bundle for the immediate generator: input beat, output beat.
// master = producer/consumer side, slave = the pipeline itself.
interface imm_gen_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [31:0]      INSTRUCTION;
    logic [2:0]       SELECT;
    logic [TAG_W-1:0] IN_TAG;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [XLEN-1:0]  OUT;
    logic [TAG_W-1:0] OUT_TAG;
    logic             OUT_ILLEGAL;

    modport master (
        output IN_VALID, INSTRUCTION, SELECT, IN_TAG, OUT_READY,
        input  IN_READY, OUT_VALID, OUT, OUT_TAG, OUT_ILLEGAL
    );

    modport slave (
        input  IN_VALID, INSTRUCTION, SELECT, IN_TAG, OUT_READY,
        output IN_READY, OUT_VALID, OUT, OUT_TAG, OUT_ILLEGAL
    );
endinterface

// File: rtl/imm_decode.sv
// Combinational immediate decoder for RV32/RV64 formats I, S, U, B, J and
// CSR zimm. Unknown select codes yield zero with the illegal flag raised.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  logic [2:0]      sel_i,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    logic [XLEN-1:0] shamt;

    // RV64 shifts use a 6-bit shamt, RV32 only 5 bits
    assign shamt = (XLEN == 64) ? XLEN'(instr_i[25:20]) : XLEN'(instr_i[24:20]);

    // Format mux; signed casts perform the sign extension to XLEN
    always_comb begin
        imm_o     = '0;
        illegal_o = 1'b0;
        unique case (sel_i)
            IMM_I: begin
                if (is_shift_imm(instr_i)) begin
                    imm_o = shamt;
                end else begin
                    imm_o = XLEN'($signed(instr_i[31:20]));
                end
            end
            IMM_S: imm_o = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
            IMM_U: imm_o = XLEN'($signed({instr_i[31:12], 12'b0}));
            IMM_B: imm_o = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                          instr_i[11:8], 1'b0}));
            IMM_J: imm_o = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                          instr_i[30:21], 1'b0}));
            IMM_Z: imm_o = XLEN'(instr_i[19:15]);
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator pipeline: decodes at the input and carries the result
// through a two-entry output/skid buffer with a fully registered ready path.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input logic       CLK,
    input logic       RESET,
    imm_gen_if.slave  bus
);

    logic [XLEN-1:0]  dec_imm;
    logic             dec_ill;

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_ill_q, out_ill_d;

    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             skid_ill_q, skid_ill_d;

    logic             in_ready;
    logic             accept;
    logic             out_free;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr_i   (bus.INSTRUCTION),
        .sel_i     (bus.SELECT),
        .imm_o     (dec_imm),
        .illegal_o (dec_ill)
    );

    // Ready depends only on the skid flop (and reset), never on OUT_READY
    assign in_ready = ~skid_valid_q & ~RESET;
    assign accept   = bus.IN_VALID & in_ready;
    // Output register can take a new beat this edge
    assign out_free = ~out_valid_q | bus.OUT_READY;

    // Next-state for output and skid registers; skid refills output first
    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_tag_d    = out_tag_q;
        out_ill_d    = out_ill_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_tag_d   = skid_tag_q;
        skid_ill_d   = skid_ill_q;

        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_tag_d    = skid_tag_q;
                out_ill_d    = skid_ill_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_imm_d   = dec_imm;
                out_tag_d   = bus.IN_TAG;
                out_ill_d   = dec_ill;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = dec_imm;
            skid_tag_d   = bus.IN_TAG;
            skid_ill_d   = dec_ill;
        end
    end

    // State registers; reset overrides any handshake on the same edge
    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_tag_q    <= '0;
            out_ill_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
            skid_ill_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_tag_q    <= out_tag_d;
            out_ill_q    <= out_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_tag_q   <= skid_tag_d;
            skid_ill_q   <= skid_ill_d;
        end
    end

    assign bus.IN_READY    = in_ready;
    assign bus.OUT_VALID   = out_valid_q;
    assign bus.OUT         = out_imm_q;
    assign bus.OUT_TAG     = out_tag_q;
    assign bus.OUT_ILLEGAL = out_ill_q;

endmodule
